// File: rtl/usb_tx_packer_pkg.sv
// Shared types and constants for the FX3 slave-FIFO write path.
// Holds the write-engine state encoding and FX3 interface constants.
package usb_tx_packer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        PKTEND
    } tx_state_t;

    localparam logic [1:0]  FX3_WR_ADDR      = 2'b00;
    localparam int unsigned FX3_FLAG_LATENCY = 3;
    localparam int unsigned WORD_W           = 32;

endpackage

// File: rtl/usb_tx_packer_if.sv
// Upstream word stream plus FX3 GPIF2 slave-FIFO write-side signals.
// master = the packer (drives the FX3 bus), slave = upstream source and FX3.
interface usb_tx_packer_if;
    import usb_tx_packer_pkg::*;

    logic              s_valid;
    logic [WORD_W-1:0] s_data;
    logic              s_ready;
    logic [WORD_W-1:0] fdata_o;
    logic              fdata_oe;
    logic [1:0]        faddr;
    logic              slcs;
    logic              slwr;
    logic              pktend;
    logic              flag_full_n;
    logic              flag_wm_n;

    modport master (
        input  s_valid, s_data, flag_full_n, flag_wm_n,
        output s_ready, fdata_o, fdata_oe, faddr, slcs, slwr, pktend
    );

    modport slave (
        output s_valid, s_data, flag_full_n, flag_wm_n,
        input  s_ready, fdata_o, fdata_oe, faddr, slcs, slwr, pktend
    );

endinterface

// File: rtl/usb_tx_fifo.sv
// First-word-fall-through buffer absorbing FX3 flag latency.
// ready is registered from the next-cycle fill level so it never admits a word into a full FIFO.
module usb_tx_fifo
    import usb_tx_packer_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             ready
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             ready_q;
    logic             do_push;
    logic             do_pop;

    assign count      = wr_ptr - rd_ptr;
    assign empty      = (count == '0);
    assign do_push    = push & ready_q;
    assign do_pop     = pop & ~empty;
    assign count_next = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    assign dout       = mem[rd_ptr[AW-1:0]];
    assign ready      = ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ready_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            ready_q <= (count_next != FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/usb_tx_packer.sv
// FX3 slave-FIFO write engine: drains buffered capture words into the write socket
// and closes partial packets with pktend after an idle timeout.
module usb_tx_packer
    import usb_tx_packer_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PKT_WORDS = 256,
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [1:0]  TX_ADDR   = FX3_WR_ADDR
) (
    input  logic            clk,
    input  logic            rst,
    usb_tx_packer_if.master bus,
    output logic            busy
);

    localparam int unsigned SYNC_STAGES = FX3_FLAG_LATENCY - 1;
    localparam int unsigned CW          = $clog2(PKT_WORDS);
    localparam int unsigned TW          = $clog2(TIMEOUT);
    localparam logic [CW-1:0] PKT_LAST   = CW'(PKT_WORDS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    tx_state_t        state_q, state_d;
    logic [CW-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [SYNC_STAGES-1:0] full_sync_q, wm_sync_q;
    logic             ok;
    logic             push;
    logic             pop;
    logic             pend;
    logic             fifo_empty;
    logic             fifo_ready;
    logic [WORD_W-1:0] fifo_head;
    logic [WORD_W-1:0] fdata_q;
    logic             fdata_oe_q;
    logic             slcs_q;
    logic             slwr_q;
    logic             pktend_q;

    usb_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (bus.s_data),
        .pop   (pop),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .ready (fifo_ready)
    );

    assign push        = bus.s_valid & fifo_ready;
    assign bus.s_ready = fifo_ready;
    assign busy        = ~fifo_empty | (pkt_cnt_q != '0);

    // FX3 flags arrive from the pclk domain; the watermark covers this delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_sync_q <= '0;
            wm_sync_q   <= '0;
        end else begin
            full_sync_q <= {full_sync_q[SYNC_STAGES-2:0], bus.flag_full_n};
            wm_sync_q   <= {wm_sync_q[SYNC_STAGES-2:0], bus.flag_wm_n};
        end
    end

    assign ok = full_sync_q[SYNC_STAGES-1] & wm_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pkt_cnt_q <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            pkt_cnt_q <= pkt_cnt_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pkt_cnt_d = pkt_cnt_q;
        timer_d   = timer_q;
        pop       = 1'b0;
        pend      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && ok) begin
                    state_d = WRITE;
                end else if (fifo_empty && pkt_cnt_q != '0 && !push) begin
                    // Timer stops at its last value by leaving IDLE, so it never wraps.
                    if (timer_q == TIMER_LAST) state_d = PKTEND;
                    else                       timer_d = timer_q + 1'b1;
                end
            end
            WRITE: begin
                timer_d = '0;
                if (!fifo_empty && ok) begin
                    pop       = 1'b1;
                    pkt_cnt_d = (pkt_cnt_q == PKT_LAST) ? '0 : pkt_cnt_q + 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            PKTEND: begin
                if (ok) begin
                    pend      = 1'b1;
                    pkt_cnt_d = '0;
                    timer_d   = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (push) timer_d = '0;
    end

    // Bus strobes are registered; fdata stays driven one cycle past the last strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slcs_q     <= 1'b1;
            slwr_q     <= 1'b1;
            pktend_q   <= 1'b1;
            fdata_oe_q <= 1'b0;
            fdata_q    <= '0;
        end else begin
            slcs_q     <= 1'b0;
            slwr_q     <= ~pop;
            pktend_q   <= ~pend;
            fdata_oe_q <= (state_d == WRITE) | pop | ~slwr_q;
            if (pop) fdata_q <= fifo_head;
        end
    end

    assign bus.slcs     = slcs_q;
    assign bus.slwr     = slwr_q;
    assign bus.pktend   = pktend_q;
    assign bus.fdata_oe = fdata_oe_q;
    assign bus.fdata_o  = fdata_q;
    assign bus.faddr    = TX_ADDR;

endmodule

// File: tb/tb_usb_tx_packer.sv
// Self-checking bench for usb_tx_packer against a queue-based model of words,
// packets and flag back-pressure.
module tb_usb_tx_packer;
    import usb_tx_packer_pkg::*;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned PKT_WORDS = 256;
    localparam int unsigned TIMEOUT   = 1024;
    localparam logic [1:0]  TX_ADDR   = 2'b00;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    usb_tx_packer_if bus();

    usb_tx_packer #(
        .DEPTH     (DEPTH),
        .PKT_WORDS (PKT_WORDS),
        .TIMEOUT   (TIMEOUT),
        .TX_ADDR   (TX_ADDR)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] src_q[$];
    logic [31:0] exp_q[$];
    bit          src_en = 1'b0;
    int unsigned words_in_pkt = 0;
    int unsigned since_wr = 0;
    int unsigned low_age = 0;
    int unsigned n_wr = 0;
    int unsigned n_pend = 0;
    int unsigned cur_run = 0;
    int unsigned max_run = 0;

    // One clock: drive inputs, advance, then check every observable against the model.
    task automatic step();
        logic xfer;
        logic flags_low;
        logic [31:0] w;
        bus.s_valid = src_en && (src_q.size() != 0);
        bus.s_data  = (src_q.size() != 0) ? src_q[0] : 32'h0;
        xfer      = bus.s_valid && bus.s_ready && !rst;
        flags_low = !(bus.flag_full_n && bus.flag_wm_n);
        @(posedge clk);
        #1;
        if (rst) begin
            low_age  = 0;
            since_wr = 0;
            cur_run  = 0;
        end else begin
            if (xfer) exp_q.push_back(src_q.pop_front());
            low_age = flags_low ? low_age + 1 : 0;
            if (bus.slwr === 1'b0) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_write: got %h with nothing pending", bus.fdata_o);
                end else begin
                    w = exp_q.pop_front();
                    if (bus.fdata_o !== w) begin
                        n_err++;
                        $display("FAIL write_data: got %h expected %h", bus.fdata_o, w);
                    end
                end
                n_vec++;
                if (bus.pktend !== 1'b1 || bus.fdata_oe !== 1'b1 || low_age >= 3) begin
                    n_err++;
                    $display("FAIL write_strobe: pktend=%b oe=%b flag_low_age=%0d, need pktend=1 oe=1 age<3",
                             bus.pktend, bus.fdata_oe, low_age);
                end
                words_in_pkt = (words_in_pkt + 1) % PKT_WORDS;
                since_wr = 0;
                n_wr++;
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                since_wr++;
                cur_run = 0;
            end
            if (bus.pktend === 1'b0) begin
                n_vec++;
                if (words_in_pkt == 0 || low_age >= 3) begin
                    n_err++;
                    $display("FAIL pktend_pulse: words_in_pkt=%0d flag_low_age=%0d, need nonzero and age<3",
                             words_in_pkt, low_age);
                end
                words_in_pkt = 0;
                n_pend++;
            end
            n_vec++;
            if (bus.s_ready !== (exp_q.size() != DEPTH)) begin
                n_err++;
                $display("FAIL s_ready: got %b expected %b (held %0d)", bus.s_ready,
                         exp_q.size() != DEPTH, exp_q.size());
            end
            n_vec++;
            if (busy !== (exp_q.size() != 0 || words_in_pkt != 0)) begin
                n_err++;
                $display("FAIL busy: got %b expected %b", busy, exp_q.size() != 0 || words_in_pkt != 0);
            end
            n_vec++;
            if (bus.slcs !== 1'b0 || bus.faddr !== TX_ADDR) begin
                n_err++;
                $display("FAIL select: slcs=%b faddr=%b expected 0 and %b", bus.slcs, bus.faddr, TX_ADDR);
            end
            if (exp_q.size() == 0 && since_wr >= 2) begin
                n_vec++;
                if (bus.fdata_oe !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle_oe: got %b expected 0", bus.fdata_oe);
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 5000 && (src_q.size() != 0 || exp_q.size() != 0); i++) step();
        repeat (2) step();
        n_vec++;
        if (src_q.size() != 0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d words still pending, expected 0", tag, src_q.size() + exp_q.size());
        end
    endtask

    task automatic wait_pktend(input string tag);
        int unsigned p0;
        p0 = n_pend;
        for (int i = 0; i < 2 * TIMEOUT && n_pend == p0; i++) step();
        n_vec++;
        if (n_pend == p0) begin
            n_err++;
            $display("FAIL %s_timeout: no pktend within %0d cycles", tag, 2 * TIMEOUT);
        end else if (since_wr < TIMEOUT + 1 || since_wr > TIMEOUT + 3) begin
            n_err++;
            $display("FAIL %s_timeout: pktend %0d cycles after last write, expected %0d..%0d",
                     tag, since_wr, TIMEOUT + 1, TIMEOUT + 3);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.flag_full_n = 1'b1;
        bus.flag_wm_n = 1'b1;
        #3;
        n_vec++;
        if (bus.slwr !== 1'b1 || bus.pktend !== 1'b1 || bus.slcs !== 1'b1 || bus.fdata_oe !== 1'b0 ||
            bus.fdata_o !== 32'h0 || bus.faddr !== TX_ADDR || bus.s_ready !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: slwr=%b pktend=%b slcs=%b oe=%b fdata=%h faddr=%b s_ready=%b busy=%b, expected 1 1 1 0 0 %b 0 0",
                     bus.slwr, bus.pktend, bus.slcs, bus.fdata_oe, bus.fdata_o, bus.faddr, bus.s_ready, busy, TX_ADDR);
        end
        step();
        step();
        rst = 1'b0;
        step();
        n_vec++;
        if (bus.slcs !== 1'b0 || bus.s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: slcs=%b s_ready=%b expected 0 1", bus.slcs, bus.s_ready);
        end
    endtask

    task automatic test_reset_mid_burst();
        src_en = 1'b1;
        for (int i = 0; i < 20; i++) src_q.push_back($urandom());
        for (int i = 0; i < 30 && bus.slwr !== 1'b0; i++) step();
        n_vec++;
        if (bus.slwr !== 1'b0) begin
            n_err++;
            $display("FAIL midburst_start: slwr=%b expected 0", bus.slwr);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (bus.slwr !== 1'b1 || bus.fdata_oe !== 1'b0 || bus.s_ready !== 1'b0 || bus.pktend !== 1'b1) begin
            n_err++;
            $display("FAIL midburst_reset: slwr=%b oe=%b s_ready=%b pktend=%b expected 1 0 0 1",
                     bus.slwr, bus.fdata_oe, bus.s_ready, bus.pktend);
        end
        src_q.delete();
        exp_q.delete();
        words_in_pkt = 0;
        src_en = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        n_vec++;
        if (busy !== 1'b0 || bus.s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midburst_release: busy=%b s_ready=%b expected 0 1", busy, bus.s_ready);
        end
        repeat (TIMEOUT + 10) step();
        n_vec++;
        if (n_pend != 0) begin
            n_err++;
            $display("FAIL midburst_pktend: %0d pktend pulses, expected 0", n_pend);
        end
    endtask

    task automatic test_short_packet();
        int unsigned w0;
        int unsigned p0;
        w0 = n_wr;
        max_run = 0;
        src_en = 1'b1;
        for (int i = 1; i <= 4; i++) src_q.push_back(32'hA000_0000 + i);
        drain("short");
        n_vec++;
        if (n_wr - w0 != 4 || max_run != 4) begin
            n_err++;
            $display("FAIL short_burst: %0d writes, longest run %0d, expected 4 and 4", n_wr - w0, max_run);
        end
        p0 = n_pend;
        wait_pktend("short");
        repeat (10) step();
        n_vec++;
        if (n_pend != p0 + 1) begin
            n_err++;
            $display("FAIL short_pktend_count: %0d pulses, expected 1", n_pend - p0);
        end
    endtask

    task automatic test_full_packet();
        int unsigned w0;
        int unsigned p0;
        w0 = n_wr;
        p0 = n_pend;
        max_run = 0;
        src_en = 1'b1;
        for (int i = 0; i < PKT_WORDS; i++) src_q.push_back($urandom());
        drain("full");
        n_vec++;
        if (n_wr - w0 != PKT_WORDS || max_run != PKT_WORDS) begin
            n_err++;
            $display("FAIL full_burst: %0d writes, longest run %0d, expected %0d", n_wr - w0, max_run, PKT_WORDS);
        end
        repeat (TIMEOUT + 20) step();
        n_vec++;
        if (n_pend != p0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL full_no_pktend: %0d pulses busy=%b, expected 0 pulses busy=0", n_pend - p0, busy);
        end
    endtask

    task automatic test_watermark_stall();
        int unsigned w0;
        w0 = n_wr;
        src_en = 1'b1;
        for (int i = 0; i < 40; i++) src_q.push_back($urandom());
        for (int i = 0; i < 100 && n_wr - w0 < 10; i++) step();
        bus.flag_wm_n = 1'b0;
        repeat (3) step();
        n_vec++;
        if (bus.slwr !== 1'b1) begin
            n_err++;
            $display("FAIL wm_stop: slwr=%b three cycles after watermark, expected 1", bus.slwr);
        end
        repeat (20) step();
        n_vec++;
        if (bus.s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL wm_full: s_ready=%b with FIFO stalled, expected 0", bus.s_ready);
        end
        bus.flag_wm_n = 1'b1;
        drain("wm");
        n_vec++;
        if (n_wr - w0 != 40) begin
            n_err++;
            $display("FAIL wm_total: %0d writes, expected 40", n_wr - w0);
        end
    endtask

    task automatic test_timeout_flag_hold();
        int unsigned p0;
        p0 = n_pend;
        bus.flag_full_n = 1'b0;
        repeat (TIMEOUT + 50) step();
        n_vec++;
        if (n_pend != p0) begin
            n_err++;
            $display("FAIL hold_pktend: %0d pulses while full, expected 0", n_pend - p0);
        end
        bus.flag_full_n = 1'b1;
        repeat (2) step();
        n_vec++;
        if (n_pend != p0) begin
            n_err++;
            $display("FAIL hold_early: pktend after 2 cycles, expected 3");
        end
        step();
        n_vec++;
        if (bus.pktend !== 1'b0) begin
            n_err++;
            $display("FAIL hold_release: pktend=%b 3 cycles after flag rise, expected 0", bus.pktend);
        end
        repeat (10) step();
        n_vec++;
        if (n_pend != p0 + 1) begin
            n_err++;
            $display("FAIL hold_once: %0d pulses, expected 1", n_pend - p0);
        end
    endtask

    task automatic test_push_in_pktend();
        int unsigned w0;
        int unsigned p0;
        src_en = 1'b1;
        src_q.push_back($urandom());
        drain("pkt6_open");
        bus.flag_full_n = 1'b0;
        repeat (TIMEOUT + 20) step();
        src_q.push_back(32'hC0DE_0001);
        step();
        bus.flag_full_n = 1'b1;
        w0 = n_wr;
        p0 = n_pend;
        repeat (2) step();
        src_q.push_back(32'hC0DE_0002);
        step();
        n_vec++;
        if (n_pend != p0 + 1 || n_wr != w0) begin
            n_err++;
            $display("FAIL pktend_order: pulses=%0d writes=%0d at pktend, expected 1 and 0", n_pend - p0, n_wr - w0);
        end
        drain("pkt6");
        n_vec++;
        if (n_wr - w0 != 2 || words_in_pkt != 2) begin
            n_err++;
            $display("FAIL pkt6_new_packet: writes=%0d open=%0d, expected 2 and 2", n_wr - w0, words_in_pkt);
        end
        wait_pktend("pkt6");
    endtask

    task automatic test_random();
        src_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0 && src_q.size() < 16) src_q.push_back($urandom());
            src_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) bus.flag_full_n = ~bus.flag_full_n;
            if ($urandom_range(0, 19) == 0) bus.flag_wm_n = ~bus.flag_wm_n;
            step();
        end
        bus.flag_full_n = 1'b1;
        bus.flag_wm_n = 1'b1;
        src_en = 1'b1;
        drain("random");
        if (words_in_pkt != 0) wait_pktend("random");
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL random_idle: busy=%b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_burst();
        test_short_packet();
        test_full_packet();
        test_watermark_stall();
        test_timeout_flag_hold();
        test_push_in_pktend();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/usb_tx_packer.md
Name: usb_tx_packer

Overview:
- Downstream write engine of the USB path: takes 32-bit capture words from the mux-to-USB stream and writes them into the FX3 GPIF2 slave FIFO.
- Absorbs FX3 flag latency in a small internal FIFO.
- Commits short packets with pktend after an idle timeout, so sparse GBA bus traffic reaches the host promptly.
- Instantiated inside usb; that block owns the read direction and the fdata tristate.

Parameters:
- DEPTH, 8: internal FIFO depth in 32-bit words, power of two, at least 4.
- PKT_WORDS, 256: words per full USB packet (1024 B); the FX3 commits full packets itself.
- TIMEOUT, 1024: idle clocks with a partial packet pending before pktend is issued.
- TX_ADDR, 2'b00: faddr value selecting the FX3 write socket.

Ports:
- clk  in  1  system clock; GPIF pclk is ~clk.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream word valid.
- s_data  in  32  upstream word.
- s_ready  out  1  upstream may transfer; transfer occurs when s_valid and s_ready are both high.
- fdata_o  out  32  data to the FX3.
- fdata_oe  out  1  high while this block drives fdata.
- faddr  out  2  FX3 socket address.
- slcs  out  1  chip select, active low.
- slwr  out  1  write strobe, active low.
- pktend  out  1  packet end, active low.
- flag_full_n  in  1  flaga; low means the write thread is full.
- flag_wm_n  in  1  flagb; low means the watermark has been reached (FX3 watermark set to cover 3-cycle latency).
- busy  out  1  FIFO non-empty or a packet is open.

Behaviour:
Reset (asynchronous):
- slwr = 1, pktend = 1, slcs = 1, fdata_oe = 0, fdata_o = 0, faddr = TX_ADDR, s_ready = 0, busy = 0.
- FIFO, word counter and timer cleared; state = IDLE.
- Reset asserted mid-packet drops all buffered data. No pktend is issued.
- On the first clock after reset release: slcs = 0, s_ready = !fifo_full.

FIFO:
- Sub-module, registered, first-word-fall-through.
- s_ready = !full.
- Simultaneous push and pop when full is allowed only if a pop occurs; s_ready is still registered from full, so no push happens when full.
- Pointers are log2(DEPTH)+1 bits and wrap naturally.

Flag inputs:
- Both flags are double-registered: ok = flag_full_n_q & flag_wm_n_q.

State machine:
- IDLE:
  - FIFO non-empty and ok -> WRITE.
  - FIFO empty and pkt_cnt != 0 -> count the timer. When timer == TIMEOUT-1 -> PKTEND.
  - Any push resets the timer to 0.
- WRITE:
  - Each cycle with FIFO non-empty and ok: pop, fdata_o = head, slwr = 0 for that cycle (registered, 1-cycle latency from pop decision), pkt_cnt++.
  - When pkt_cnt reaches PKT_WORDS-1 and a word is written, pkt_cnt wraps to 0; no pktend.
  - FIFO empty or !ok -> IDLE, with slwr = 1 the next cycle.
- PKTEND:
  - One cycle: pktend = 0, slwr = 1, only if ok; otherwise hold in PKTEND until ok.
  - Then pkt_cnt = 0, timer = 0 -> IDLE.
  - A push arriving while in PKTEND is buffered; it is not written until the next cycle.

Output rules:
- fdata_oe = 1 from the first WRITE cycle through the cycle after the last slwr.
- fdata_oe = 0 in IDLE with slwr high.
- slwr and pktend are never low in the same cycle. (A zero-length packet is impossible because pktend requires pkt_cnt != 0.)
- The timer saturates and never wraps.
- busy = !empty | (pkt_cnt != 0).

Decomposition:
- gba_io_fpga_header.svh gains:
  - tx_state_t enum: IDLE, WRITE, PKTEND.
  - localparam FX3_WR_ADDR = 2'b00.
  - The FX3 flag latency constant, 3.
- Sub-module: usb_tx_fifo, parameterised on DEPTH, width 32.

Test Plan:
1. Reset asserted while slwr is low mid-burst -> same-cycle slwr = 1, fdata_oe = 0, s_ready = 0. After release, busy = 0.
2. Push 4 words 0xA0000001..4, flags high -> slwr low for 4 consecutive cycles, fdata_o in order. After 1024 idle cycles, one pktend low pulse and pkt_cnt = 0.
3. Push 256 words back-to-back, flags high -> 256 slwr strobes, pkt_cnt wraps to 0, no pktend ever, busy drops.
4. flag_wm_n low mid-burst after word 10 -> slwr high within 3 cycles, remaining words held. FIFO fills and s_ready = 0 at DEPTH words. Flag high again -> writes resume with no loss or duplication.
5. Timeout expires while flag_full_n is low -> pktend held off, then issued exactly once, 3 cycles after the flag rises.
6. Push during the PKTEND cycle -> that word is written in the next packet, after pktend, and opens a new timeout window.
